// File: rtl/branch_predictor_v2.sv
// Branch predictor with a configurable-index PHT of saturating counters, local or global history,
// a one-cycle registered prediction path and a saturating misprediction counter.
module branch_predictor_v2 #(
    parameter int ADDR_WIDTH     = 32,
    parameter int HASH_WIDTH     = 4,
    parameter int HISTORY_LENGTH = 4,
    parameter int CNT_WIDTH      = 2,
    parameter int MODE           = 1,
    parameter int STAT_WIDTH     = 16
) (
    input  logic                  Sys_clk,
    input  logic                  Sys_rst_n,
    input  logic                  Sys_rdy,
    input  logic                  IFPD_predict_en,
    input  logic [ADDR_WIDTH-1:0] IFPD_pc,
    input  logic                  IFPD_feedback_en,
    input  logic [ADDR_WIDTH-1:0] IFPD_feedback_pc,
    input  logic                  IFPD_branch_result,
    input  logic                  IFPD_feedback_predicted,
    output logic                  PDIF_predict_valid,
    output logic                  PDIF_predict_result,
    output logic [STAT_WIDTH-1:0] PDIF_mispredict_cnt
);

    localparam int IDX_W     = HASH_WIDTH + HISTORY_LENGTH;
    localparam int PHT_DEPTH = 1 << IDX_W;
    localparam int BHR_DEPTH = 1 << HASH_WIDTH;
    localparam logic [CNT_WIDTH-1:0]  CNT_INIT = {1'b0, {(CNT_WIDTH-1){1'b1}}};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_MIN  = {CNT_WIDTH{1'b0}};
    localparam logic [STAT_WIDTH-1:0] MISS_MAX = {STAT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0]      pht_q [PHT_DEPTH];
    logic [HISTORY_LENGTH-1:0] bhr_q [BHR_DEPTH];
    logic [HISTORY_LENGTH-1:0] ghr_q;
    logic                      valid_q;
    logic                      result_q;
    logic [STAT_WIDTH-1:0]     miss_q;

    logic [HASH_WIDTH-1:0]     pred_hash_s;
    logic [HASH_WIDTH-1:0]     fb_hash_s;
    logic [IDX_W-1:0]          pred_idx_s;
    logic [IDX_W-1:0]          fb_idx_s;
    logic [HISTORY_LENGTH-1:0] fb_hist_base_s;
    logic [HISTORY_LENGTH-1:0] fb_hist_d;
    logic [CNT_WIDTH-1:0]      fb_cnt_d;
    logic [STAT_WIDTH-1:0]     miss_d;
    logic                      unused_s;

    function automatic logic [IDX_W-1:0] pht_index(
        input logic [ADDR_WIDTH-1:0]     pc,
        input logic [HISTORY_LENGTH-1:0] lhist,
        input logic [HISTORY_LENGTH-1:0] ghist
    );
        logic [IDX_W-1:0] idx;
        case (MODE)
            32'sd1:  idx = {pc[HASH_WIDTH+1:2], lhist};
            32'sd2:  idx = pc[IDX_W+1:2] ^ {{HASH_WIDTH{1'b0}}, ghist};
            default: idx = pc[IDX_W+1:2];
        endcase
        return idx;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_step(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 taken
    );
        logic [CNT_WIDTH-1:0] nxt;
        if (taken) begin
            nxt = (cnt == CNT_MAX) ? cnt : cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            nxt = (cnt == CNT_MIN) ? cnt : cnt - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    // Index and next-state computation; everything reads pre-edge state, so no bypass exists.
    always_comb begin
        pred_hash_s = IFPD_pc[HASH_WIDTH+1:2];
        fb_hash_s   = IFPD_feedback_pc[HASH_WIDTH+1:2];
        pred_idx_s  = pht_index(IFPD_pc, bhr_q[pred_hash_s], ghr_q);
        fb_idx_s    = pht_index(IFPD_feedback_pc, bhr_q[fb_hash_s], ghr_q);
        fb_cnt_d    = sat_step(pht_q[fb_idx_s], IFPD_branch_result);
        if (MODE == 32'sd1) begin
            fb_hist_base_s = bhr_q[fb_hash_s];
        end else begin
            fb_hist_base_s = ghr_q;
        end
        fb_hist_d = {fb_hist_base_s[HISTORY_LENGTH-2:0], IFPD_branch_result};
        if (IFPD_feedback_en && (IFPD_branch_result != IFPD_feedback_predicted)
                && (miss_q != MISS_MAX)) begin
            miss_d = miss_q + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            miss_d = miss_q;
        end
    end

    assign unused_s = ^{IFPD_pc, IFPD_feedback_pc, ghr_q};

    // Table, history and output registers; Sys_rdy low freezes everything and drops valid.
    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht_q[i] <= CNT_INIT;
            end
            for (int i = 0; i < BHR_DEPTH; i++) begin
                bhr_q[i] <= {HISTORY_LENGTH{1'b0}};
            end
            ghr_q    <= {HISTORY_LENGTH{1'b0}};
            valid_q  <= 1'b0;
            result_q <= 1'b0;
            miss_q   <= {STAT_WIDTH{1'b0}};
        end else if (Sys_rdy) begin
            valid_q <= IFPD_predict_en;
            if (IFPD_predict_en) begin
                result_q <= pht_q[pred_idx_s][CNT_WIDTH-1];
            end
            if (IFPD_feedback_en) begin
                pht_q[fb_idx_s] <= fb_cnt_d;
                if (MODE == 32'sd1) begin
                    bhr_q[fb_hash_s] <= fb_hist_d;
                end
                if (MODE == 32'sd2) begin
                    ghr_q <= fb_hist_d;
                end
            end
            miss_q <= miss_d;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign PDIF_predict_valid  = valid_q;
    assign PDIF_predict_result = result_q;
    assign PDIF_mispredict_cnt = miss_q;

endmodule

// File: tb/tb_branch_predictor_v2.sv
// Bench for branch_predictor_v2: one instance per indexing mode on shared stimulus, checked every
// cycle against an arithmetic reference model, plus directed literal expectations.
module tb_branch_predictor_v2;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        pe;
    logic [31:0] pcv;
    logic        fe;
    logic [31:0] fpcv;
    logic        res;
    logic        fpred;

    logic [2:0]       pv;
    logic [2:0]       pr;
    logic [2:0][15:0] mc;

    int checks;
    int errors;
    bit chk_en;

    int cnt_m [3][256];
    int bhr_m [16];
    int ghr_m;
    int ev [3];
    int er [3];
    int em [3];

    branch_predictor_v2 #(.MODE(0)) u_bim (
        .Sys_clk(clk), .Sys_rst_n(rst_n), .Sys_rdy(rdy),
        .IFPD_predict_en(pe), .IFPD_pc(pcv),
        .IFPD_feedback_en(fe), .IFPD_feedback_pc(fpcv),
        .IFPD_branch_result(res), .IFPD_feedback_predicted(fpred),
        .PDIF_predict_valid(pv[0]), .PDIF_predict_result(pr[0]), .PDIF_mispredict_cnt(mc[0])
    );

    branch_predictor_v2 #(.MODE(1)) u_loc (
        .Sys_clk(clk), .Sys_rst_n(rst_n), .Sys_rdy(rdy),
        .IFPD_predict_en(pe), .IFPD_pc(pcv),
        .IFPD_feedback_en(fe), .IFPD_feedback_pc(fpcv),
        .IFPD_branch_result(res), .IFPD_feedback_predicted(fpred),
        .PDIF_predict_valid(pv[1]), .PDIF_predict_result(pr[1]), .PDIF_mispredict_cnt(mc[1])
    );

    branch_predictor_v2 #(.MODE(2)) u_gsh (
        .Sys_clk(clk), .Sys_rst_n(rst_n), .Sys_rdy(rdy),
        .IFPD_predict_en(pe), .IFPD_pc(pcv),
        .IFPD_feedback_en(fe), .IFPD_feedback_pc(fpcv),
        .IFPD_branch_result(res), .IFPD_feedback_predicted(fpred),
        .PDIF_predict_valid(pv[2]), .PDIF_predict_result(pr[2]), .PDIF_mispredict_cnt(mc[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_idx(input int m, input logic [31:0] p);
        int unsigned w;
        w = p >> 2;
        case (m)
            0:       return int'(w % 256);
            1:       return int'((w % 16) * 16) + bhr_m[w % 16];
            default: return int'(w % 256) ^ ghr_m;
        endcase
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 256; i++) cnt_m[m][i] = 1;
            ev[m] = 0;
            er[m] = 0;
            em[m] = 0;
        end
        for (int i = 0; i < 16; i++) bhr_m[i] = 0;
        ghr_m = 0;
    endtask

    task automatic model_step();
        int ip [3];
        int ifb [3];
        int c;
        int unsigned h;
        for (int m = 0; m < 3; m++) begin
            ip[m]  = model_idx(m, pcv);
            ifb[m] = model_idx(m, fpcv);
        end
        for (int m = 0; m < 3; m++) begin
            ev[m] = pe ? 1 : 0;
            if (pe) er[m] = (cnt_m[m][ip[m]] >= 2) ? 1 : 0;
        end
        if (fe) begin
            for (int m = 0; m < 3; m++) begin
                c = cnt_m[m][ifb[m]];
                if (res) c = (c < 3) ? c + 1 : 3;
                else     c = (c > 0) ? c - 1 : 0;
                cnt_m[m][ifb[m]] = c;
                if (res != fpred && em[m] < 65535) em[m] = em[m] + 1;
            end
            h = (fpcv >> 2) % 16;
            bhr_m[h] = (bhr_m[h] * 2 + (res ? 1 : 0)) % 16;
            ghr_m    = (ghr_m * 2 + (res ? 1 : 0)) % 16;
        end
    endtask

    // Reference model advances on the same edges as the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else if (rdy) model_step();
        else for (int m = 0; m < 3; m++) ev[m] = 0;
    end

    // Mid-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 3; m++) begin
                check($sformatf("valid_m%0d", m), int'(pv[m]), ev[m]);
                check($sformatf("result_m%0d", m), int'(pr[m]), er[m]);
                check($sformatf("misscnt_m%0d", m), int'(mc[m]), em[m]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p_en, input logic [31:0] p_pc, input logic f_en,
                         input logic [31:0] f_pc, input logic r, input logic fp);
        pe = p_en; pcv = p_pc; fe = f_en; fpcv = f_pc; res = r; fpred = fp;
        step();
    endtask

    task automatic do_reset();
        pe = 1'b0; fe = 1'b0; rdy = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0; chk_en = 1'b0;
        rst_n = 1'b0; rdy = 1'b1;
        pe = 1'b0; pcv = 32'h0; fe = 1'b0; fpcv = 32'h0; res = 1'b0; fpred = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Reset values, then local-history predict of 0x100.
        check("rst_valid", int'(pv), 0);
        check("rst_misscnt_m1", int'(mc[1]), 0);
        drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        check("A_valid", int'(pv[1]), 1);
        check("A_result", int'(pr[1]), 0);
        check("A_misscnt", int'(mc[1]), 0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("A_pulse_end", int'(pv[1]), 0);

        // Bimodal counter walk on 0x104, including saturation at both ends.
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 1'b0);
        check("B_model_cnt_10", cnt_m[0][65], 2);
        drive(1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 1'b0);
        check("B_model_cnt_11", cnt_m[0][65], 3);
        drive(1'b1, 32'h104, 1'b1, 32'h104, 1'b1, 1'b1);
        check("B_pred_taken", int'(pr[0]), 1);
        check("B_model_cnt_sat_hi", cnt_m[0][65], 3);
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 1'b1);
        check("B_model_cnt_00", cnt_m[0][65], 0);
        drive(1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 1'b1);
        check("B_model_cnt_sat_lo", cnt_m[0][65], 0);
        drive(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0);
        check("B_pred_not_taken", int'(pr[0]), 0);
        check("B_misscnt", int'(mc[0]), 6);

        // Local history learns an alternating pattern on 0x200.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 1'b0);
            drive(1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 1'b0);
        end
        check("C_model_bhr_1010", bhr_m[0], 10);
        drive(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
        check("C_pred_after_N", int'(pr[1]), 1);
        drive(1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 1'b0);
        check("C_model_bhr_0101", bhr_m[0], 5);
        drive(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
        check("C_pred_after_T", int'(pr[1]), 0);
        check("C_misscnt", int'(mc[1]), 9);

        // Gshare: two taken outcomes give GHR=0011, then 0x18 indexes 6^3=5.
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 32'h14, 1'b1, 1'b1);
        check("D_model_ghr", ghr_m, 3);
        check("D_model_cnt5", cnt_m[2][5], 1);
        drive(1'b1, 32'h18, 1'b0, 32'h0, 1'b0, 1'b0);
        check("D_pred", int'(pr[2]), 0);
        check("D_valid", int'(pv[2]), 1);

        // Same-cycle predict and feedback on one PC: no bypass.
        do_reset();
        drive(1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 1'b0);
        check("E_same_cycle", int'(pr[0]), 0);
        drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
        check("E_next_cycle", int'(pr[0]), 1);

        // Sys_rdy low freezes state and suppresses valid.
        rdy = 1'b0;
        drive(1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 1'b1);
        check("F_frozen_valid", int'(pv), 0);
        check("F_held_result", int'(pr[0]), 1);
        drive(1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 1'b1);
        check("F_frozen_misscnt", int'(mc[0]), 1);
        rdy = 1'b1;
        drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
        check("F_counter_kept", int'(pr[0]), 1);
        check("F_valid_back", int'(pv[0]), 1);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("G_async_valid", int'(pv), 0);
        check("G_async_result", int'(pr), 0);
        check("G_async_cnt_m0", int'(mc[0]), 0);
        check("G_async_cnt_m1", int'(mc[1]), 0);
        pe = 1'b0; fe = 1'b0;
        step();
        rst_n = 1'b1;
        drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
        check("G_after_reset_pred", int'(pr[0]), 0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
